mastermind_scorer: RTL and testbench
====================================

// Module: mastermind_scorer
// PURPOSE
//  Sequential, parametrised Mastermind guess scorer with a start/done handshake.
//  Counts exact (right colour, right slot) and partial (right colour, wrong slot) matches,
//  using the histogram method so duplicate colours score correctly.
//  Drives per-slot feedback digits to the SSD driver and owns win / turn-limit / game_over sequencing.
//  Sits between the guess-entry/history logic and the display mux.
// PARAMETERS
//  NPEGS      4   number of slots per code/guess (>=2)
//  CW         3   colour field width; 2**CW colours
//  MAX_TURNS  8   guesses allowed before forced game over (MM_TURN_LIMIT_EN only)
//  END_DELAY  4   clk cycles from ending event to game_over assertion (>=1)
// PORTS
//  clk          in   1            system clock, all state on rising edge
//  rst_n        in   1            asynchronous active-low reset
//  new_game     in   1            sync clear of turn/win/end state; wins over start
//  start        in   1            score request; sampled only when idle and !game_over
//  code         in   NPEGS*CW     secret; slot i = code[i*CW +: CW]
//  guess        in   NPEGS*CW     guess; same slot packing
//  busy         out  1            high from cycle after accepted start until done
//  done         out  1            one-cycle pulse, results valid from this cycle
//  exact_cnt    out  CNTW         CNTW = $clog2(NPEGS+1)
//  partial_cnt  out  CNTW
//  feedback     out  2*NPEGS      slot k = feedback[2k +: 2]; FB_EXACT first, then FB_PARTIAL, rest FB_NONE
//  win          out  1            exact_cnt == NPEGS on last done; sticky until new_game
//  turn_cnt     out  $clog2(MAX_TURNS+1)   completed scorings this game
//  game_over    out  1            sticky until new_game
// BEHAVIOUR
//  Reset: FSM IDLE; all outputs, histograms and counters 0.
//  Accepted start latches code/guess. Inputs ignored afterwards.
//  FSM: IDLE -> EXACT -> MINSUM -> FINISH -> IDLE.
//  EXACT: NPEGS cycles, slot i per cycle.
//    Equal colours: exact+1.
//    Unequal colours: hist_c[code_i]+1 and hist_g[guess_i]+1.
//  MINSUM: 2**CW cycles, colour j per cycle; partial += min(hist_c[j], hist_g[j]).
//  FINISH: 1 cycle.
//    Registers exact_cnt/partial_cnt/feedback; pulses done.
//    Updates win/turn_cnt; clears histograms.
//  Latency: done exactly NPEGS + 2**CW + 1 cycles after the accepted start edge.
//  Outputs hold between scorings.
//  Widths: counters CNTW bits; exact+partial <= NPEGS, so no overflow.
//  start while busy, in FINISH, or with game_over=1: ignored, no queueing.
//  Ending event: win, or (MM_TURN_LIMIT_EN) turn_cnt reaches MAX_TURNS.
//  End sequencing:
//    An ending event arms end_cnt, which counts 1..END_DELAY from the cycle after done.
//    game_over rises when end_cnt == END_DELAY.
//    No further starts are accepted once armed.
//  new_game: any state -> IDLE same edge.
//    Clears win, turn_cnt, end_cnt, game_over, histograms.
//    Aborts scoring with no done; score outputs are kept.
//  new_game && start on the same edge: start dropped.
//  rst_n low mid-scoring: immediate abort, no done.
// CONFIGURATION
//  MM_TURN_LIMIT_EN defined:
//    turn_cnt increments on each done, saturating at MAX_TURNS.
//    Reaching MAX_TURNS without win is an ending event.
//  Not defined:
//    No turn counter logic; turn_cnt tied 0.
//    Only win ends the game.
// STRUCTURE
//  mm_pkg: FB_NONE=2'd0, FB_PARTIAL=2'd1, FB_EXACT=2'd2.
//  mm_pkg: FSM state encoding ST_IDLE/ST_EXACT/ST_MINSUM/ST_FINISH.
//  mm_pkg: clog2-derived width constants.
//  Sub-module mm_feedback_encode (combinational).
//    Maps (exact_cnt, partial_cnt) -> thermometer feedback vector.
//    Reused by the history display.
// TESTING (NPEGS=4, CW=3, END_DELAY=4)
//  1. code 1,2,3,4 guess 1,2,3,4
//     -> exact 4, partial 0, feedback all FB_EXACT, win=1.
//     -> game_over rises 4 cycles after done.
//  2. code 1,1,2,2 guess 2,2,1,1
//     -> exact 0, partial 4, feedback all FB_PARTIAL, win=0.
//  3. code 1,1,1,2 guess 1,2,2,2
//     -> exact 2, partial 0, feedback {EXACT,EXACT,NONE,NONE}.
//  4. start pulse, second start 3 cycles later, code 5,6,7,0 guess 0,5,6,1
//     -> single done at cycle 13; busy high cycles 1..12; exact 0, partial 3.
//  5. MM_TURN_LIMIT_EN, MAX_TURNS=3, three non-winning guesses
//     -> turn_cnt 3; game_over 4 cycles after 3rd done; 4th start ignored.
//     -> new_game clears all.
//  6. rst_n low in MINSUM cycle 2
//     -> all outputs 0, no done; next start scores correctly from clean histograms.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared constants for the Mastermind scorer: feedback digit codes, scorer FSM
// encoding and clog2-based width helpers.
package mm_pkg;

  localparam logic [1:0] FB_NONE    = 2'd0;
  localparam logic [1:0] FB_PARTIAL = 2'd1;
  localparam logic [1:0] FB_EXACT   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXACT  = 2'd1,
    ST_MINSUM = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int count_w(input int max_val);
    return (max_val < 32'sd1) ? 32'sd1 : $clog2(max_val + 32'sd1);
  endfunction

  // Bits needed to index n items (at least one bit).
  function automatic int index_w(input int n);
    return (n < 32'sd2) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mm_feedback_encode.sv
// Combinational thermometer encoder: exact pegs fill the low slots, partial pegs
// follow, remaining slots are blank. Shared with the history display.
module mm_feedback_encode
  import mm_pkg::*;
#(
  parameter int NPEGS = 4,
  parameter int CNTW  = count_w(NPEGS)
) (
  input  logic [CNTW-1:0]    exact_cnt_i,
  input  logic [CNTW-1:0]    partial_cnt_i,
  output logic [2*NPEGS-1:0] feedback_o
);

  // Slot k compares against the running exact / exact+partial boundaries.
  always_comb begin
    feedback_o = '0;
    for (int k = 0; k < NPEGS; k++) begin
      if (k < int'(exact_cnt_i)) begin
        feedback_o[2*k +: 2] = FB_EXACT;
      end else if (k < int'(exact_cnt_i) + int'(partial_cnt_i)) begin
        feedback_o[2*k +: 2] = FB_PARTIAL;
      end else begin
        feedback_o[2*k +: 2] = FB_NONE;
      end
    end
  end

endmodule

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer (histogram method) with win / game_over sequencing.
// Optional turn limit enabled by defining MM_TURN_LIMIT_EN.
module mastermind_scorer
  import mm_pkg::*;
#(
  parameter  int NPEGS     = 4,
  parameter  int CW        = 3,
  parameter  int MAX_TURNS = 8,
  parameter  int END_DELAY = 4,
  localparam int CNTW      = count_w(NPEGS),
  localparam int TW        = count_w(MAX_TURNS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  new_game,
  input  logic                  start,
  input  logic [NPEGS*CW-1:0]   code,
  input  logic [NPEGS*CW-1:0]   guess,
  output logic                  busy,
  output logic                  done,
  output logic [CNTW-1:0]       exact_cnt,
  output logic [CNTW-1:0]       partial_cnt,
  output logic [2*NPEGS-1:0]    feedback,
  output logic                  win,
  output logic [TW-1:0]         turn_cnt,
  output logic                  game_over
);

  localparam int NCOL = 1 << CW;
  localparam int IW   = index_w(NPEGS);
  localparam int EW   = count_w(END_DELAY);

  state_t                state_q, state_d;
  logic [NPEGS*CW-1:0]   code_q, code_d, guess_q, guess_d;
  logic [IW-1:0]         slot_q, slot_d;
  logic [CW-1:0]         col_q, col_d;
  logic [CNTW-1:0]       exact_acc_q, exact_acc_d, partial_acc_q, partial_acc_d;
  logic [CNTW-1:0]       exact_cnt_q, exact_cnt_d, partial_cnt_q, partial_cnt_d;
  logic [CNTW-1:0]       hist_c_q [NCOL];
  logic [CNTW-1:0]       hist_c_d [NCOL];
  logic [CNTW-1:0]       hist_g_q [NCOL];
  logic [CNTW-1:0]       hist_g_d [NCOL];
  logic [2*NPEGS-1:0]    feedback_q, feedback_d, feedback_s;
  logic                  busy_q, busy_d, done_q, done_d, win_q, win_d;
  logic                  armed_q, armed_d, game_over_q, game_over_d;
  logic [EW-1:0]         end_cnt_q, end_cnt_d;
  logic [CW-1:0]         code_slot_s, guess_slot_s;
  logic                  fin_s, turn_end_s;

  function automatic logic [CNTW-1:0] min_cnt(input logic [CNTW-1:0] a, input logic [CNTW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  assign code_slot_s  = code_q[int'(slot_q)*CW +: CW];
  assign guess_slot_s = guess_q[int'(slot_q)*CW +: CW];
  assign fin_s        = (state_q == ST_FINISH) && !new_game;

  mm_feedback_encode #(.NPEGS(NPEGS), .CNTW(CNTW)) u_fb_enc (
    .exact_cnt_i   (exact_acc_q),
    .partial_cnt_i (partial_acc_q),
    .feedback_o    (feedback_s)
  );

  // Scoring FSM and datapath next-state; new_game overrides every state.
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    guess_d       = guess_q;
    slot_d        = slot_q;
    col_d         = col_q;
    exact_acc_d   = exact_acc_q;
    partial_acc_d = partial_acc_q;
    hist_c_d      = hist_c_q;
    hist_g_d      = hist_g_q;
    exact_cnt_d   = exact_cnt_q;
    partial_cnt_d = partial_cnt_q;
    feedback_d    = feedback_q;
    win_d         = win_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    if (new_game) begin
      state_d = ST_IDLE;
      win_d   = 1'b0;
      for (int j = 0; j < NCOL; j++) begin
        hist_c_d[j] = '0;
        hist_g_d[j] = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !game_over_q && !armed_q) begin
            state_d       = ST_EXACT;
            code_d        = code;
            guess_d       = guess;
            slot_d        = '0;
            col_d         = '0;
            exact_acc_d   = '0;
            partial_acc_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EXACT: begin
          busy_d = 1'b1;
          if (code_slot_s == guess_slot_s) begin
            exact_acc_d = exact_acc_q + CNTW'(1);
          end else begin
            hist_c_d[code_slot_s]  = hist_c_q[code_slot_s] + CNTW'(1);
            hist_g_d[guess_slot_s] = hist_g_q[guess_slot_s] + CNTW'(1);
          end
          if (slot_q == IW'(NPEGS - 1)) begin
            state_d = ST_MINSUM;
          end else begin
            slot_d = slot_q + IW'(1);
          end
        end
        ST_MINSUM: begin
          busy_d        = 1'b1;
          partial_acc_d = partial_acc_q + min_cnt(hist_c_q[col_q], hist_g_q[col_q]);
          if (col_q == CW'(NCOL - 1)) begin
            state_d = ST_FINISH;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        ST_FINISH: begin
          done_d        = 1'b1;
          exact_cnt_d   = exact_acc_q;
          partial_cnt_d = partial_acc_q;
          feedback_d    = feedback_s;
          win_d         = win_q | (exact_acc_q == CNTW'(NPEGS));
          state_d       = ST_IDLE;
          for (int j = 0; j < NCOL; j++) begin
            hist_c_d[j] = '0;
            hist_g_d[j] = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // End sequencing: arm on the ending done, then count up to END_DELAY.
  always_comb begin
    armed_d     = armed_q;
    end_cnt_d   = end_cnt_q;
    game_over_d = game_over_q;
    if (new_game) begin
      armed_d     = 1'b0;
      end_cnt_d   = '0;
      game_over_d = 1'b0;
    end else if (fin_s && (win_d || turn_end_s)) begin
      armed_d   = 1'b1;
      end_cnt_d = '0;
    end else if (armed_q && (end_cnt_q != EW'(END_DELAY))) begin
      end_cnt_d   = end_cnt_q + EW'(1);
      game_over_d = (end_cnt_d == EW'(END_DELAY)) ? 1'b1 : game_over_q;
    end else begin
      end_cnt_d = end_cnt_q;
    end
  end

`ifdef MM_TURN_LIMIT_EN
  logic [TW-1:0] turn_cnt_q, turn_cnt_d;

  // Completed-scoring counter, saturating at the turn limit.
  always_comb begin
    turn_cnt_d = turn_cnt_q;
    if (new_game) begin
      turn_cnt_d = '0;
    end else if (fin_s && (turn_cnt_q != TW'(MAX_TURNS))) begin
      turn_cnt_d = turn_cnt_q + TW'(1);
    end else begin
      turn_cnt_d = turn_cnt_q;
    end
  end

  // Turn counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turn_cnt_q <= '0;
    end else begin
      turn_cnt_q <= turn_cnt_d;
    end
  end

  assign turn_end_s = (turn_cnt_d == TW'(MAX_TURNS));
  assign turn_cnt   = turn_cnt_q;
`else
  assign turn_end_s = 1'b0;
  assign turn_cnt   = '0;
`endif

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      code_q        <= '0;
      guess_q       <= '0;
      slot_q        <= '0;
      col_q         <= '0;
      exact_acc_q   <= '0;
      partial_acc_q <= '0;
      exact_cnt_q   <= '0;
      partial_cnt_q <= '0;
      feedback_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      win_q         <= 1'b0;
      armed_q       <= 1'b0;
      game_over_q   <= 1'b0;
      end_cnt_q     <= '0;
      for (int j = 0; j < NCOL; j++) begin
        hist_c_q[j] <= '0;
        hist_g_q[j] <= '0;
      end
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      guess_q       <= guess_d;
      slot_q        <= slot_d;
      col_q         <= col_d;
      exact_acc_q   <= exact_acc_d;
      partial_acc_q <= partial_acc_d;
      exact_cnt_q   <= exact_cnt_d;
      partial_cnt_q <= partial_cnt_d;
      feedback_q    <= feedback_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      win_q         <= win_d;
      armed_q       <= armed_d;
      game_over_q   <= game_over_d;
      end_cnt_q     <= end_cnt_d;
      hist_c_q      <= hist_c_d;
      hist_g_q      <= hist_g_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign exact_cnt   = exact_cnt_q;
  assign partial_cnt = partial_cnt_q;
  assign feedback    = feedback_q;
  assign win         = win_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Self-checking bench for mastermind_scorer (NPEGS=4, CW=3, MAX_TURNS=3, END_DELAY=4).
// Turn-limit checks follow MM_TURN_LIMIT_EN.
module tb_mastermind_scorer;

  localparam int NPEGS = 4;
  localparam int CW    = 3;
  localparam int MAXT  = 3;
  localparam int ENDD  = 4;
  localparam int LAT   = NPEGS + (1 << CW) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_game = 1'b0;
  logic        start = 1'b0;
  logic [11:0] code = 12'd0;
  logic [11:0] guess = 12'd0;
  logic        busy, done, win, game_over;
  logic [2:0]  exact_cnt, partial_cnt;
  logic [7:0]  feedback;
  logic [1:0]  turn_cnt;

  int          tests = 0;
  int          fails = 0;
  int          exp_win = 0;
  int          exp_turn = 0;
  int          last_ex = 0;
  int          last_pa = 0;
  logic [7:0]  last_fb = 8'd0;

  always #5 clk = ~clk;

  mastermind_scorer #(.NPEGS(NPEGS), .CW(CW), .MAX_TURNS(MAXT), .END_DELAY(ENDD)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .start(start),
    .code(code), .guess(guess), .busy(busy), .done(done),
    .exact_cnt(exact_cnt), .partial_cnt(partial_cnt), .feedback(feedback),
    .win(win), .turn_cnt(turn_cnt), .game_over(game_over)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pack(input int a, input int b, input int c, input int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  // Reference: exact = same-slot matches; total colour overlap minus exact = partial.
  function automatic void model(input logic [11:0] c, input logic [11:0] g,
                                output int ex, output int pa, output logic [7:0] fb);
    int hc[8];
    int hg[8];
    int overlap;
    logic [2:0] ci, gi;
    for (int j = 0; j < 8; j++) begin
      hc[j] = 0;
      hg[j] = 0;
    end
    ex = 0;
    for (int i = 0; i < NPEGS; i++) begin
      ci = c[i*3 +: 3];
      gi = g[i*3 +: 3];
      if (ci == gi) ex++;
      hc[ci]++;
      hg[gi]++;
    end
    overlap = 0;
    for (int j = 0; j < 8; j++) overlap += (hc[j] < hg[j]) ? hc[j] : hg[j];
    pa = overlap - ex;
    fb = 8'd0;
    for (int k = 0; k < NPEGS; k++)
      fb[2*k +: 2] = (k < ex) ? 2'd2 : ((k < ex + pa) ? 2'd1 : 2'd0);
  endfunction

  task automatic score(input string tag, input logic [11:0] c, input logic [11:0] g,
                       input int restart_at);
    int ex, pa, n, busy_n;
    logic [7:0] fb;
    bit seen;
    model(c, g, ex, pa, fb);
    code = c;
    guess = g;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    busy_n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      if (restart_at > 0 && n == restart_at) begin
        start = 1'b1;
        code = ~c;
        guess = ~g;
      end
      tick();
      start = 1'b0;
      n++;
      if (busy) busy_n++;
      if (done) seen = 1;
    end
    if (ex == NPEGS) exp_win = 1;
`ifdef MM_TURN_LIMIT_EN
    if (exp_turn < MAXT) exp_turn++;
`endif
    last_ex = ex;
    last_pa = pa;
    last_fb = fb;
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_busy_cycles"}, busy_n, LAT - 1);
    chk({tag, "_exact"}, exact_cnt, ex);
    chk({tag, "_partial"}, partial_cnt, pa);
    chk({tag, "_feedback"}, feedback, fb);
    chk({tag, "_win"}, win, exp_win);
    chk({tag, "_turn"}, turn_cnt, exp_turn);
    tick();
    chk({tag, "_done_one_cycle"}, done, 0);
  endtask

  task automatic measure_gameover(input string tag);
    int k;
    k = 1;
    while (!game_over && k < 30) begin
      tick();
      k++;
    end
    chk(tag, k, ENDD);
  endtask

  task automatic expect_ignored(input string tag);
    int b;
    code = pack(1, 2, 3, 5);
    guess = pack(1, 2, 3, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    b = 0;
    for (int i = 0; i < 16; i++) begin
      if (busy || done) b++;
      tick();
    end
    chk(tag, b, 0);
  endtask

  task automatic do_new_game(input string tag);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    exp_win = 0;
    exp_turn = 0;
    chk({tag, "_win"}, win, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_turn"}, turn_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [11:0] rc, rg;
    int cnt;
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_exact", exact_cnt, 0);
    chk("reset_partial", partial_cnt, 0);
    chk("reset_feedback", feedback, 0);
    chk("reset_win", win, 0);
    chk("reset_turn", turn_cnt, 0);
    chk("reset_game_over", game_over, 0);
    rst_n = 1'b1;
    tick();

    // Three non-winning turns; the first has a second start mid-scoring.
    score("restart", pack(5, 6, 7, 0), pack(0, 5, 6, 1), 2);
    score("dup_partial", pack(1, 1, 2, 2), pack(2, 2, 1, 1), 0);
    score("dup_exact", pack(1, 1, 1, 2), pack(1, 2, 2, 2), 0);
`ifdef MM_TURN_LIMIT_EN
    measure_gameover("turn_limit_gameover");
    expect_ignored("start_after_turn_limit");
`else
    repeat (10) tick();
    chk("no_gameover_without_limit", game_over, 0);
`endif
    do_new_game("ng1");

    score("win", pack(1, 2, 3, 4), pack(1, 2, 3, 4), 0);
    measure_gameover("win_gameover");
    expect_ignored("start_when_over");
    chk("win_sticky", win, 1);
    do_new_game("ng2");

    score("win2", pack(7, 0, 7, 0), pack(7, 0, 7, 0), 0);
    expect_ignored("start_while_armed");
    chk("armed_gameover", game_over, 1);
    do_new_game("ng3");

    // new_game and start on the same edge: start dropped.
    new_game = 1'b1;
    start = 1'b1;
    tick();
    new_game = 1'b0;
    start = 1'b0;
    cnt = 0;
    repeat (6) begin
      if (busy || done) cnt++;
      tick();
    end
    chk("ng_and_start", cnt, 0);

    // new_game mid-scoring aborts without done and keeps the old scores.
    code = pack(3, 3, 3, 3);
    guess = pack(3, 3, 3, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    cnt = 0;
    repeat (20) begin
      if (busy || done) cnt++;
      tick();
    end
    chk("abort_no_done", cnt, 0);
    chk("abort_keep_exact", exact_cnt, last_ex);
    chk("abort_keep_partial", partial_cnt, last_pa);
    chk("abort_keep_feedback", feedback, last_fb);
    chk("abort_win", win, 0);

    // Reset during the second MINSUM cycle.
    code = pack(2, 4, 6, 1);
    guess = pack(4, 2, 1, 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_exact", exact_cnt, 0);
    chk("rst_mid_partial", partial_cnt, 0);
    chk("rst_mid_feedback", feedback, 0);
    exp_win = 0;
    exp_turn = 0;
    tick();
    tick();
    chk("rst_mid_no_done", done, 0);
    rst_n = 1'b1;
    tick();
    score("after_rst", pack(3, 3, 4, 5), pack(3, 4, 3, 7), 0);

    // Randomised scorings, each in a fresh game.
    for (int it = 0; it < 12; it++) begin
      do_new_game("rng");
      rc = 12'($urandom);
      rg = rc;
      for (int s = 0; s < NPEGS; s++)
        if ($urandom_range(0, 1) == 0) rg[s*3 +: 3] = 3'($urandom);
      score("rand", rc, rg, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
